// File: rtl/controller_interface_if.sv
// CPU bus and controller-port signals of the game-controller interface.
// The slave modport is the controller_interface block; master is whatever drives it.
interface controller_interface_if;
    logic        clk_enable;
    logic [15:0] cpu_address;
    logic        write_enable_B;
    logic [7:0]  data_out;
    logic        data_enable;
    logic        controller_latch;
    logic        controller_clk_enable;
    logic        controller_1_data_in_B;
    logic        controller_2_data_in_B;
    logic [7:0]  controller_1_buttons_out;
    logic [7:0]  controller_2_buttons_out;

    modport slave (
        input  clk_enable,
        input  cpu_address,
        input  write_enable_B,
        output data_out,
        output data_enable,
        output controller_latch,
        output controller_clk_enable,
        input  controller_1_data_in_B,
        input  controller_2_data_in_B,
        output controller_1_buttons_out,
        output controller_2_buttons_out
    );

    modport master (
        output clk_enable,
        output cpu_address,
        output write_enable_B,
        input  data_out,
        input  data_enable,
        input  controller_latch,
        input  controller_clk_enable,
        output controller_1_data_in_B,
        output controller_2_data_in_B,
        input  controller_1_buttons_out,
        input  controller_2_buttons_out
    );
endinterface

// File: rtl/controller_interface.sv
// Polls two NES-style serial controllers in a 10-step latch/shift/commit loop
// and exposes the committed button bytes on the CPU data bus.
module controller_interface #(
    parameter logic [15:0] CONTROLLER_1_ADDR = 16'h7000,
    parameter logic [15:0] CONTROLLER_2_ADDR = 16'h7001
) (
    input  logic                   clk_1,
    input  logic                   rst_B,
    controller_interface_if.slave  bus
);

    typedef enum logic [1:0] {
        PH_LATCH,
        PH_SHIFT,
        PH_COMMIT
    } phase_e;

    localparam logic [3:0] LAST_STATE = 4'd9;

    logic [3:0] state_q, state_d;
    logic [7:0] shadow_1_q, shadow_1_d;
    logic [7:0] shadow_2_q, shadow_2_d;
    logic [7:0] buttons_1_q, buttons_1_d;
    logic [7:0] buttons_2_q, buttons_2_d;

    phase_e     phase;
    logic [2:0] bit_idx;
    logic       latch_strobe;
    logic       shift_strobe;

    // NOTE: the reset is synchronous, so it lives inside the clocked branch and
    // only takes effect on a clk_1 edge.
    always_ff @(posedge clk_1) begin
        if (!rst_B) begin
            state_q     <= 4'd0;
            shadow_1_q  <= 8'h00;
            shadow_2_q  <= 8'h00;
            buttons_1_q <= 8'h00;
            buttons_2_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            shadow_1_q  <= shadow_1_d;
            shadow_2_q  <= shadow_2_d;
            buttons_1_q <= buttons_1_d;
            buttons_2_q <= buttons_2_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        shadow_1_d   = shadow_1_q;
        shadow_2_d   = shadow_2_q;
        buttons_1_d  = buttons_1_q;
        buttons_2_d  = buttons_2_q;
        latch_strobe = 1'b0;
        shift_strobe = 1'b0;
        bit_idx      = 3'(4'd8 - state_q);

        // Out-of-range counts fall into COMMIT so the loop always recovers to 0.
        if (state_q == 4'd0) begin
            phase = PH_LATCH;
        end else if (state_q >= LAST_STATE) begin
            phase = PH_COMMIT;
        end else begin
            phase = PH_SHIFT;
        end

        if (bus.clk_enable) begin
            state_d = (state_q >= LAST_STATE) ? 4'd0 : state_q + 4'd1;
            unique case (phase)
                PH_LATCH: latch_strobe = 1'b1;
                PH_SHIFT: begin
                    // Sample precedes the controller's shift on this same edge.
                    shift_strobe        = 1'b1;
                    shadow_1_d[bit_idx] = ~bus.controller_1_data_in_B;
                    shadow_2_d[bit_idx] = ~bus.controller_2_data_in_B;
                end
                PH_COMMIT: begin
                    buttons_1_d = shadow_1_q;
                    buttons_2_d = shadow_2_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.controller_latch         = latch_strobe & rst_B;
    assign bus.controller_clk_enable    = shift_strobe & rst_B;
    assign bus.controller_1_buttons_out = buttons_1_q;
    assign bus.controller_2_buttons_out = buttons_2_q;

    logic hit_1, hit_2;
    assign hit_1 = (bus.cpu_address == CONTROLLER_1_ADDR);
    assign hit_2 = (bus.cpu_address == CONTROLLER_2_ADDR);

    // Writes never enable the bus driver; the registers are read-only.
    assign bus.data_enable = bus.write_enable_B & (hit_1 | hit_2);
    assign bus.data_out    = hit_1 ? buttons_1_q :
                             hit_2 ? buttons_2_q : 8'h00;

endmodule

// File: tb/tb_controller_interface.sv
// Directed bench for controller_interface: behavioural shift-register controllers,
// a commit scoreboard fed by the stimulus, and direct strobe/bus checks.
module tb_controller_interface;

    logic clk_1;
    logic rst_B;
    controller_interface_if bus ();

    controller_interface dut (
        .clk_1 (clk_1),
        .rst_B (rst_B),
        .bus   (bus)
    );

    initial begin
        clk_1 = 1'b0;
        forever #5 clk_1 = ~clk_1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Controllers: load on latch, shift MSB-first on clk enable, line is active-low.
    logic [7:0] btn_1, btn_2;
    logic [7:0] sr_1 = 8'h00;
    logic [7:0] sr_2 = 8'h00;

    always @(posedge clk_1) begin
        if (bus.controller_latch) begin
            sr_1 <= btn_1;
            sr_2 <= btn_2;
        end else if (bus.controller_clk_enable) begin
            sr_1 <= {sr_1[6:0], 1'b0};
            sr_2 <= {sr_2[6:0], 1'b0};
        end
    end

    assign bus.controller_1_data_in_B = ~sr_1[7];
    assign bus.controller_2_data_in_B = ~sr_2[7];

    // Scoreboard: stimulus pushes {c1, c2} per poll it expects to complete.
    logic [15:0] exp_q[$];
    logic        commit_seen = 1'b0;

    always @(posedge clk_1) begin
        commit_seen <= bus.clk_enable && rst_B &&
                       !bus.controller_latch && !bus.controller_clk_enable;
    end

    always @(negedge clk_1) begin
        if (commit_seen) begin
            check("commit_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [15:0] exp_v;
                exp_v = exp_q.pop_front();
                check("commit_c1", 32'(bus.controller_1_buttons_out), 32'(exp_v[15:8]));
                check("commit_c2", 32'(bus.controller_2_buttons_out), 32'(exp_v[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk_1);
        @(negedge clk_1);
    endtask

    task automatic run_poll(input logic [7:0] b1, input logic [7:0] b2);
        btn_1 = b1;
        btn_2 = b2;
        exp_q.push_back({b1, b2});
        repeat (10) tick();
    endtask

    task automatic cpu_read(input logic [15:0] addr, input logic we_b,
                            input logic [7:0] exp_data, input logic exp_en, input string name);
        bus.cpu_address    = addr;
        bus.write_enable_B = we_b;
        #1;
        check({name, "_data"}, 32'(bus.data_out), 32'(exp_data));
        check({name, "_en"}, 32'(bus.data_enable), 32'(exp_en));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_B              = 1'b0;
        bus.clk_enable     = 1'b1;
        bus.cpu_address    = 16'h0000;
        bus.write_enable_B = 1'b1;
        btn_1              = 8'b1000_1001;
        btn_2              = 8'b0010_0110;

        // Reset held: registers cleared and both strobes low.
        repeat (3) tick();
        check("rst_c1", 32'(bus.controller_1_buttons_out), 32'h00);
        check("rst_c2", 32'(bus.controller_2_buttons_out), 32'h00);
        check("rst_latch", 32'(bus.controller_latch), 32'd0);
        check("rst_clken", 32'(bus.controller_clk_enable), 32'd0);
        cpu_read(16'h7000, 1'b1, 8'h00, 1'b1, "rst_read");

        // First poll: strobe pattern 1 latch, 8 shifts, 1 idle; outputs only after edge 10.
        rst_B = 1'b1;
        exp_q.push_back({8'h89, 8'h26});
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("seq_latch_%0d", i), 32'(bus.controller_latch), 32'(i == 0));
            check($sformatf("seq_clken_%0d", i), 32'(bus.controller_clk_enable), 32'(i >= 1 && i <= 8));
            check($sformatf("seq_hold_%0d", i), 32'(bus.controller_1_buttons_out), 32'h00);
            tick();
        end
        check("first_c1", 32'(bus.controller_1_buttons_out), 32'h89);
        check("first_c2", 32'(bus.controller_2_buttons_out), 32'h26);

        cpu_read(16'h7000, 1'b1, 8'h89, 1'b1, "read_7000");
        cpu_read(16'h7001, 1'b1, 8'h26, 1'b1, "read_7001");
        cpu_read(16'h7003, 1'b1, 8'h00, 1'b0, "read_7003");
        cpu_read(16'h7000, 1'b0, 8'h89, 1'b0, "write_7000");
        bus.write_enable_B = 1'b1;
        bus.cpu_address    = 16'h0000;

        // Controller 1 changes at state 4: this poll still commits the latched 0x89.
        exp_q.push_back({8'h89, 8'h26});
        repeat (4) tick();
        btn_1 = 8'hFF;
        repeat (6) tick();
        check("midpoll_c1", 32'(bus.controller_1_buttons_out), 32'h89);
        run_poll(8'hFF, 8'h26);
        check("nextpoll_c1", 32'(bus.controller_1_buttons_out), 32'hFF);

        // clk_enable toggling: 20 clk_1 cycles per poll, strobes low while disabled.
        btn_1 = 8'h5A;
        btn_2 = 8'hC3;
        exp_q.push_back({8'h5A, 8'hC3});
        for (int i = 0; i < 20; i++) begin
            bus.clk_enable = (i % 2 == 0);
            #1;
            if (i == 1) begin
                check("gated_clken", 32'(bus.controller_clk_enable), 32'd0);
                check("gated_latch", 32'(bus.controller_latch), 32'd0);
            end
            if (i == 18) begin
                check("gated_hold_c1", 32'(bus.controller_1_buttons_out), 32'hFF);
            end
            tick();
        end
        bus.clk_enable = 1'b1;
        check("gated_c1", 32'(bus.controller_1_buttons_out), 32'h5A);
        check("gated_c2", 32'(bus.controller_2_buttons_out), 32'hC3);

        // Reset at state 5 aborts the poll; nothing from it is expected.
        btn_1 = 8'h12;
        btn_2 = 8'h34;
        repeat (5) tick();
        rst_B = 1'b0;
        #1;
        check("midrst_clken_low", 32'(bus.controller_clk_enable), 32'd0);
        tick();
        check("midrst_c1", 32'(bus.controller_1_buttons_out), 32'h00);
        check("midrst_c2", 32'(bus.controller_2_buttons_out), 32'h00);
        rst_B = 1'b1;
        #1;
        check("midrst_state0_latch", 32'(bus.controller_latch), 32'd1);
        check("midrst_state0_clken", 32'(bus.controller_clk_enable), 32'd0);
        run_poll(8'h12, 8'h34);
        check("postrst_c1", 32'(bus.controller_1_buttons_out), 32'h12);
        check("postrst_c2", 32'(bus.controller_2_buttons_out), 32'h34);

        bus.clk_enable = 1'b0;
        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
